mul_sequencer: RTL and testbench

//  Multi-cycle shift-add multiplier controller for the MUL/UMULL/SMULL ops of the ALU opcode space.

---
 rtl/mul_sequencer_if.sv | 41 ++++
 rtl/mul_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mul_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// -----------------------------------------------------------------------------
// mul_sequencer_if
// Handshake and data bundle between the control unit and the multi-cycle
// multiplier sequencer.
//   master : control unit side (drives start/op/a/b, observes results)
//   slave  : sequencer side (observes request, drives busy/done/results/err)
// Signals:
//   start      request pulse, only honoured while the sequencer is idle
//   op         3-bit ALU op: 100=MUL, 101=UMULL, 111=SMULL
//   a, b       multiplicand / multiplier
//   busy       sequencer working (CALC and FIX)
//   done       one-cycle completion pulse
//   result_lo  product[WIDTH-1:0]
//   result_hi  product[2*WIDTH-1:WIDTH] (0 for MUL)
//   flags      {N,Z,C,V}
//   err        one-cycle pulse on an illegal op request
// -----------------------------------------------------------------------------
interface mul_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic [3:0]       flags;
   logic             err;

   modport master (
      output start, op, a, b,
      input  busy, done, result_lo, result_hi, flags, err
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result_lo, result_hi, flags, err
   );
endinterface

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Multi-cycle shift-add multiplier for MUL / UMULL / SMULL. One partial
// product per CALC cycle, sign fix-up in FIX, one-cycle done pulse in DONE.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    mul_sequencer_if.slave (start/op/a/b in; busy/done/results/flags/err out)
// Configuration:
//   MUL_SEQ_EARLY_TERM_EN  when defined, CALC stops as soon as the remaining
//                          multiplier bits are zero (at least one CALC cycle);
//                          FIX realigns the accumulator by the skipped shifts.
//                          Undefined: fixed WIDTH CALC cycles.
// -----------------------------------------------------------------------------
module mul_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic           clk,
   input  logic           reset,
   mul_sequencer_if.slave bus
);

   localparam logic [2:0] OpMul   = 3'b100;
   localparam logic [2:0] OpUmull = 3'b101;
   localparam logic [2:0] OpSmull = 3'b111;

   localparam logic [WIDTH-1:0]   OneW  = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] One2W = (2*WIDTH)'(1);
   localparam logic [CNT_W-1:0]   OneC  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   LastC = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e           r_state;
   state_e           w_state_next;

   logic [2:0]       r_op;
   logic             r_neg;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplr;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_res_lo;
   logic [WIDTH-1:0] r_res_hi;
   logic [3:0]       r_flags;
   logic             r_err;

   logic               w_op_legal;
   logic               w_is_smull;
   logic               w_accept;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_sum;
   logic               w_calc_last;
   logic [2*WIDTH-1:0] w_prod_raw;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_res_hi;
   logic [3:0]         w_flags;

   // ---------------------------------------------------------------- request
   assign w_op_legal = (bus.op == OpMul) || (bus.op == OpUmull) || (bus.op == OpSmull);
   assign w_is_smull = (bus.op == OpSmull);
   assign w_accept   = (r_state == StIdle) && bus.start && w_op_legal;

   // Magnitudes only for SMULL; -2^(W-1) maps onto 2^(W-1) as unsigned.
   assign w_abs_a = (w_is_smull && bus.a[WIDTH-1]) ? (~bus.a + OneW) : bus.a;
   assign w_abs_b = (w_is_smull && bus.b[WIDTH-1]) ? (~bus.b + OneW) : bus.b;

   // --------------------------------------------------------------- datapath
   // Carry out of the add becomes the MSB of acc_hi after the shift.
   assign w_sum = {1'b0, r_acc_hi} + (r_mplr[0] ? {1'b0, r_mcand} : '0);

`ifdef MUL_SEQ_EARLY_TERM_EN
   logic [CNT_W-1:0] w_shamt;

   // Bits still in r_mplr after this iteration are all zero -> nothing left to add.
   assign w_calc_last = (r_cnt == LastC) || (r_mplr[WIDTH-1:1] == '0);
   // After k of WIDTH iterations the acc holds product << (WIDTH-k).
   assign w_shamt     = CNT_W'(WIDTH) - r_cnt;
   assign w_prod_raw  = {r_acc_hi, r_acc_lo} >> w_shamt;
`else
   assign w_calc_last = (r_cnt == LastC);
   assign w_prod_raw  = {r_acc_hi, r_acc_lo};
`endif

   assign w_prod   = ((r_op == OpSmull) && r_neg) ? (~w_prod_raw + One2W) : w_prod_raw;
   assign w_res_hi = (r_op == OpMul) ? '0 : w_prod[2*WIDTH-1:WIDTH];

   always_comb begin
      w_flags    = 4'b0000;
      w_flags[3] = (r_op == OpSmull) && w_prod[2*WIDTH-1];
      w_flags[2] = (w_prod[WIDTH-1:0] == '0) && (w_res_hi == '0);
   end

   // -------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (w_accept) w_state_next = StCalc;
         StCalc:  if (w_calc_last) w_state_next = StFix;
         StFix:   w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // ------------------------------------------------------ registered state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op     <= '0;
         r_neg    <= 1'b0;
         r_mcand  <= '0;
         r_mplr   <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_cnt    <= '0;
         r_res_lo <= '0;
         r_res_hi <= '0;
         r_flags  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= (r_state == StIdle) && bus.start && !w_op_legal;

         if (w_accept) begin
            r_op     <= bus.op;
            r_neg    <= w_is_smull && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_mcand  <= w_abs_a;
            r_mplr   <= w_abs_b;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
         end

         if (r_state == StCalc) begin
            r_acc_hi <= w_sum[WIDTH:1];
            r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
            r_mplr   <= r_mplr >> 1;
            r_cnt    <= r_cnt + OneC;
         end

         if (r_state == StFix) begin
            r_res_lo <= w_prod[WIDTH-1:0];
            r_res_hi <= w_res_hi;
            r_flags  <= w_flags;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.busy      = (r_state == StCalc) || (r_state == StFix);
   assign bus.done      = (r_state == StDone);
   assign bus.result_lo = r_res_lo;
   assign bus.result_hi = r_res_hi;
   assign bus.flags     = r_flags;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
// Scoreboard bench: the driver pushes hand-computed expected results when it
// issues a request; a negedge monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_sequencer_if #(.WIDTH(32)) bus ();

   mul_sequencer #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic [3:0]  fl;
      int          start_cyc;
      int          lat;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      logic [3:0]  fl;
   } vec_t;

   exp_t sb_q[$];
   int   n_pass = 0;
   int   n_tot  = 0;
   int   err_exp_cyc = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Expected done latency measured from the start cycle.
   function automatic int lat_of(input logic [2:0] op, input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
      logic [31:0] m;
      int          n;
      m = (op == 3'b111 && b[31]) ? (~b + 32'd1) : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return n + 2;
`else
      if (op == 3'b000 && b == 32'd0) return 0;  // keeps args referenced
      return 34;
`endif
   endfunction

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (bus.done) begin
         if (sb_q.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_done: done seen with no request pending (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("result_lo", bus.result_lo, e.lo);
            chk("result_hi", bus.result_hi, e.hi);
            chk("flags", bus.flags, e.fl);
            chk("done_latency", cyc - e.start_cyc, e.lat);
            chk("busy_at_done", bus.busy, 1'b0);
         end
      end
      if (bus.err) chk("err_cycle", cyc, err_exp_cyc);
   end

   // ----------------------------------------------------------------- driver
   // Returns in the cycle after the start cycle with start low.
   task automatic issue(input vec_t v, input logic push);
      exp_t e;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op    = v.op;
      bus.a     = v.a;
      bus.b     = v.b;
      if (push) begin
         e.lo = v.lo; e.hi = v.hi; e.fl = v.fl;
         e.start_cyc = cyc;
         e.lat = lat_of(v.op, v.b);
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb_q.size() != 0) begin
         n_tot++;
         $display("FAIL done_timeout: %0d requests still pending after 200 cycles", sb_q.size());
         sb_q.delete();
      end
   endtask

   vec_t vecs[10];

   initial begin
      vec_t ign;
      vecs[0] = '{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b0000};
      vecs[1] = '{3'b111, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b1000};
      vecs[2] = '{3'b100, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100};
      vecs[3] = '{3'b111, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 4'b0000};
      vecs[4] = '{3'b101, 32'h0000_0005, 32'h0000_0003, 32'h0000_000F, 32'h0000_0000, 4'b0000};
      vecs[5] = '{3'b101, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100};
      vecs[6] = '{3'b100, 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, 32'h0000_0000, 4'b0000};
      vecs[7] = '{3'b111, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 4'b1000};
      vecs[8] = '{3'b111, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_000F, 32'h0000_0000, 4'b0000};
      vecs[9] = '{3'b101, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 4'b0000};

      bus.start = 1'b0;
      bus.op    = 3'b000;
      bus.a     = '0;
      bus.b     = '0;
      reset     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_lo", bus.result_lo, 32'h0);
      chk("rst_hi", bus.result_hi, 32'h0);
      chk("rst_flags", bus.flags, 4'h0);

      // Directed vectors, back to back.
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i], 1'b1);
         chk("busy_after_accept", bus.busy, 1'b1);
         wait_idle();
      end

      // Second start at cycle 10 of an operation must be ignored.
      issue(vecs[0], 1'b1);
      repeat (9) @(posedge clk);
      #1;
      chk("busy_mid_calc", bus.busy, 1'b1);
      ign = '{3'b101, 32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0, 4'h0};
      bus.start = 1'b1; bus.op = ign.op; bus.a = ign.a; bus.b = ign.b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_idle();
      repeat (40) @(posedge clk);

      // Illegal op: err one cycle later, never busy.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h3; bus.b = 32'h4;
      err_exp_cyc = cyc + 1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("err_pulse", bus.err, 1'b1);
      chk("busy_on_err", bus.busy, 1'b0);
      @(posedge clk); #1;
      chk("err_one_cycle", bus.err, 1'b0);
      chk("busy_after_err", bus.busy, 1'b0);

      // Reset at cycle 15 of an operation drops it; a fresh start completes.
      issue(vecs[0], 1'b1);
      repeat (14) @(posedge clk);
      #1;
      reset = 1'b1;
      sb_q.delete();
      @(posedge clk); #1;
      chk("rst_mid_busy", bus.busy, 1'b0);
      chk("rst_mid_done", bus.done, 1'b0);
      chk("rst_mid_lo", bus.result_lo, 32'h0);
      chk("rst_mid_hi", bus.result_hi, 32'h0);
      chk("rst_mid_flags", bus.flags, 4'h0);
      reset = 1'b0;
      issue(vecs[1], 1'b1);
      wait_idle();

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
